// File: rtl/epp_bram_bridge.sv
// ============================================================================
// epp_bram_bridge
// ----------------------------------------------------------------------------
// Bridges an EPP (Enhanced Parallel Port) slave interface to a dual-port byte
// RAM. The host sees a small register file. The whole memory is reached
// through a single DATA register, backed by an auto-incrementing pointer, so
// bulk transfers need no address cycle per byte. A second synchronous port
// gives fabric logic concurrent read/write access to the same memory.
//
// Parameters:
//   ADDR_W  memory address width (9..16); depth = 2**ADDR_W bytes
//   ID      constant returned by the ID register
//
// Ports:
//   clk      system clock, all logic on the rising edge
//   rst      synchronous, active-high reset
//   EppAstb  EPP address strobe, active low, asynchronous to clk
//   EppDstb  EPP data strobe, active low, asynchronous to clk
//   EppWr    EPP direction, 0 = host write, 1 = host read, asynchronous
//   db_in    DB pad input value
//   db_out   value driven onto DB while db_oe = 1
//   db_oe    DB output enable for the top-level tristate
//   EppWait  handshake acknowledge to the host
//   b_addr   fabric port address
//   b_din    fabric write data
//   b_we     fabric write enable
//   b_dout   fabric read data, one-cycle latency, read-first
//
// Register map (selected by the 8-bit EPP address register):
//   0x00 PTR_L  RW  pointer[7:0]
//   0x01 PTR_H  RW  pointer[ADDR_W-1:8], unused bits read 0
//   0x02 DATA   RW  mem[pointer], optional post-increment
//   0x03 CTRL   RW  bit0 = auto-increment enable (reset 1)
//   0x04 ID     RO  returns ID
//   others          read 0x00, writes ignored
// ============================================================================
module epp_bram_bridge #(
    parameter int         ADDR_W = 12,
    parameter logic [7:0] ID     = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EppAstb,
    input  logic              EppDstb,
    input  logic              EppWr,
    input  logic [7:0]        db_in,
    output logic [7:0]        db_out,
    output logic              db_oe,
    output logic              EppWait,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_din,
    input  logic              b_we,
    output logic [7:0]        b_dout
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int HI_W  = ADDR_W - 8;

    localparam logic [7:0] REG_PTR_L = 8'h00;
    localparam logic [7:0] REG_PTR_H = 8'h01;
    localparam logic [7:0] REG_DATA  = 8'h02;
    localparam logic [7:0] REG_CTRL  = 8'h03;
    localparam logic [7:0] REG_ID    = 8'h04;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RDMEM = 2'd1,
        ACK   = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Strobe synchronisers. Bit order is {wr, dstb, astb}. Resetting to all
    // ones makes the bridge look at an idle bus right after reset, so a
    // strobe still held low afterwards is seen as a fresh falling edge.
    // ------------------------------------------------------------------------
    logic [2:0] strb_meta;
    logic [2:0] strb_sync;
    logic       astb_s;
    logic       dstb_s;
    logic       wr_s;

    // NOTE: clocked state is always assigned with <= so that every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            strb_meta <= 3'b111;
            strb_sync <= 3'b111;
        end else begin
            strb_meta <= {EppWr, EppDstb, EppAstb};
            strb_sync <= strb_meta;
        end
    end

    assign astb_s = strb_sync[0];
    assign dstb_s = strb_sync[1];
    assign wr_s   = strb_sync[2];

    // ------------------------------------------------------------------------
    // Bridge state
    // ------------------------------------------------------------------------
    state_t            state;
    logic [7:0]        epp_addr;
    logic [ADDR_W-1:0] pointer;
    logic              auto_inc;
    logic [ADDR_W-1:0] ptr_inc;
    logic [7:0]        reg_rdata;
    logic [7:0]        a_q;
    logic              mem_we;

    // Wraps naturally from DEPTH-1 to 0.
    assign ptr_inc = pointer + ADDR_W'(1);

    // Host write of DATA is committed in IDLE, in the same cycle the FSM
    // moves to ACK. Address strobe has priority over data strobe.
    assign mem_we = !rst && (state == IDLE) && astb_s && !dstb_s && !wr_s
                    && (epp_addr == REG_DATA);

    // Read value of every non-memory register. DATA is served from the RAM
    // through the RDMEM state and therefore has no entry here.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        reg_rdata = 8'h00;
        case (epp_addr)
            REG_PTR_L: reg_rdata = pointer[7:0];
            REG_PTR_H: reg_rdata = 8'(pointer[ADDR_W-1:8]);
            REG_CTRL:  reg_rdata = {7'b0, auto_inc};
            REG_ID:    reg_rdata = ID;
            default:   reg_rdata = 8'h00;
        endcase
    end

    // ------------------------------------------------------------------------
    // EPP handshake FSM with registered outputs. EppWait and db_oe are set on
    // entry to ACK and cleared on the way back to IDLE, so both are glitch-free
    // and always assert in the same cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            EppWait  <= 1'b0;
            db_oe    <= 1'b0;
            db_out   <= 8'h00;
            epp_addr <= 8'h00;
            pointer  <= '0;
            auto_inc <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!astb_s) begin
                        // Address cycle, also taken when both strobes are low.
                        if (!wr_s) begin
                            epp_addr <= db_in;
                        end else begin
                            db_out <= epp_addr;
                        end
                        state   <= ACK;
                        EppWait <= 1'b1;
                        db_oe   <= wr_s;
                    end else if (!dstb_s) begin
                        if (!wr_s) begin
                            // Register write; the DATA byte itself goes to
                            // the RAM through mem_we.
                            case (epp_addr)
                                REG_PTR_L: pointer[7:0] <= db_in;
                                REG_PTR_H: pointer[ADDR_W-1:8] <= db_in[HI_W-1:0];
                                REG_DATA:  if (auto_inc) pointer <= ptr_inc;
                                REG_CTRL:  auto_inc <= db_in[0];
                                default:   ;
                            endcase
                            state   <= ACK;
                            EppWait <= 1'b1;
                            db_oe   <= 1'b0;
                        end else if (epp_addr == REG_DATA) begin
                            // RAM read is already in flight into a_q.
                            state <= RDMEM;
                        end else begin
                            db_out  <= reg_rdata;
                            state   <= ACK;
                            EppWait <= 1'b1;
                            db_oe   <= 1'b1;
                        end
                    end
                end

                RDMEM: begin
                    db_out  <= a_q;
                    if (auto_inc) begin
                        pointer <= ptr_inc;
                    end
                    state   <= ACK;
                    EppWait <= 1'b1;
                    db_oe   <= wr_s;
                end

                ACK: begin
                    // Hold the acknowledge until the host has released both
                    // strobes.
                    if (astb_s && dstb_s) begin
                        state   <= IDLE;
                        EppWait <= 1'b0;
                        db_oe   <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    EppWait <= 1'b0;
                    db_oe   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Dual-port RAM. Port A (EPP) reads mem[pointer] every cycle; the FSM
    // only consumes it in RDMEM. Port B is read-first. On a same-address
    // write collision the EPP write wins.
    // ------------------------------------------------------------------------
    logic [7:0] mem [0:DEPTH-1];

    // NOTE: the array has no reset branch on purpose; a RAM cannot be
    // cleared in one cycle and a reset term would prevent block-RAM mapping.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[pointer] <= db_in;
        end
        if (b_we && !(mem_we && (b_addr == pointer))) begin
            mem[b_addr] <= b_din;
        end
        a_q <= mem[pointer];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_dout <= 8'h00;
        end else begin
            b_dout <= mem[b_addr];
        end
    end

endmodule

// File: tb/tb_epp_bram_bridge.sv
// ============================================================================
// tb_epp_bram_bridge
// ----------------------------------------------------------------------------
// Self-checking bench for epp_bram_bridge. A transaction-level model keeps a
// byte array for the memory plus the host-visible register values. Host
// transfers are checked for latency, direction and data. A per-cycle
// compare process checks the fabric read port against the model array.
// ============================================================================
module tb_epp_bram_bridge;

    localparam int AW = 12;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          EppAstb;
    logic          EppDstb;
    logic          EppWr;
    logic [7:0]    db_in;
    logic [7:0]    db_out;
    logic          db_oe;
    logic          EppWait;
    logic [AW-1:0] b_addr;
    logic [7:0]    b_din;
    logic          b_we;
    logic [7:0]    b_dout;

    epp_bram_bridge #(.ADDR_W(AW), .ID(8'hA5)) dut (
        .clk     (clk),
        .rst     (rst),
        .EppAstb (EppAstb),
        .EppDstb (EppDstb),
        .EppWr   (EppWr),
        .db_in   (db_in),
        .db_out  (db_out),
        .db_oe   (db_oe),
        .EppWait (EppWait),
        .b_addr  (b_addr),
        .b_din   (b_din),
        .b_we    (b_we),
        .b_dout  (b_dout)
    );

    initial forever #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    logic [7:0]    mem_m [DEPTH];
    bit            known [DEPTH];
    int            cyc = 0;
    int            wr_edge = -1;
    int            rd_edge = -1;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [7:0]    wr_data = '0;
    logic [7:0]    rd_capture = '0;
    logic [7:0]    exp_bdout = '0;
    bit            exp_known = 1'b0;

    logic [AW-1:0] m_ptr;
    bit            m_auto;
    logic [7:0]    m_addr;

    // Fabric stimulus controls
    bit            fab_rand = 1'b0;
    logic          man_we = 1'b0;
    logic [AW-1:0] man_addr = '0;
    logic [7:0]    man_din = '0;
    bit            collide = 1'b0;
    logic [7:0]    coll_din = '0;
    bit            chk_on = 1'b0;

    // Memory model: one update per rising edge. A host DATA access lands
    // three edges after its strobe is driven low (two synchroniser stages
    // plus the FSM decision). Port B is read-first, and the EPP write wins
    // a same-address collision.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            exp_bdout = 8'h00;
            exp_known = 1'b1;
        end else begin
            exp_bdout = mem_m[b_addr];
            exp_known = known[b_addr];
            if (cyc == rd_edge) rd_capture = mem_m[rd_addr];
            if (cyc == wr_edge) begin
                mem_m[wr_addr] = wr_data;
                known[wr_addr] = 1'b1;
            end
            if (b_we && !(cyc == wr_edge && b_addr == wr_addr)) begin
                mem_m[b_addr] = b_din;
                known[b_addr] = 1'b1;
            end
        end
    end

    // Fabric driver: updates shortly after each rising edge.
    initial begin
        b_we = 1'b0;
        b_addr = '0;
        b_din = '0;
        forever begin
            @(posedge clk);
            #2;
            if (collide && wr_edge == cyc + 1) begin
                b_we   = 1'b1;
                b_addr = wr_addr;
                b_din  = coll_din;
            end else if (fab_rand) begin
                b_we   = ($urandom_range(0, 3) == 0);
                b_addr = AW'($urandom);
                b_din  = 8'($urandom);
            end else begin
                b_we   = man_we;
                b_addr = man_addr;
                b_din  = man_din;
            end
        end
    end

    // Per-cycle compare of the fabric port and of the output-enable rule.
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            if (exp_known) check("b_dout", {24'h0, b_dout}, {24'h0, exp_bdout});
            if (db_oe === 1'b1) check("db_oe_needs_wait", {31'h0, EppWait}, 32'h1);
        end
    end

    // ------------------------------------------------------------------------
    // Host transfer. addr_cyc selects an address cycle, both drives both
    // strobes low, wr = 1 means host write.
    // ------------------------------------------------------------------------
    task automatic epp_xfer(input bit addr_cyc, input bit both, input bit wr,
                            input logic [7:0] wdata, output logic [7:0] rdata);
        int         n;
        int         exp_lat;
        bit         mem_rd;
        logic [7:0] exp_rd;
        exp_lat = 3;
        mem_rd  = 1'b0;
        exp_rd  = 8'h00;
        @(negedge clk);
        if (addr_cyc) begin
            if (wr) m_addr = wdata;
            else    exp_rd = m_addr;
        end else if (wr) begin
            case (m_addr)
                8'h00: m_ptr[7:0] = wdata;
                8'h01: m_ptr[11:8] = wdata[3:0];
                8'h02: begin
                    wr_edge = cyc + 3;
                    wr_addr = m_ptr;
                    wr_data = wdata;
                    if (m_auto) m_ptr = m_ptr + 1'b1;
                end
                8'h03: m_auto = wdata[0];
                default: ;
            endcase
        end else begin
            case (m_addr)
                8'h00: exp_rd = m_ptr[7:0];
                8'h01: exp_rd = {4'h0, m_ptr[11:8]};
                8'h02: begin
                    rd_edge = cyc + 3;
                    rd_addr = m_ptr;
                    exp_lat = 4;
                    mem_rd  = 1'b1;
                    if (m_auto) m_ptr = m_ptr + 1'b1;
                end
                8'h03: exp_rd = {7'h0, m_auto};
                8'h04: exp_rd = 8'hA5;
                default: exp_rd = 8'h00;
            endcase
        end
        EppWr   = !wr;
        db_in   = wdata;
        EppAstb = !(addr_cyc || both);
        EppDstb = !(!addr_cyc || both);
        n = 0;
        while (n < 12) begin
            @(negedge clk);
            n++;
            if (EppWait) break;
        end
        check("wait_rise_latency", n, exp_lat);
        check("db_oe_in_ack", {31'h0, db_oe}, {31'h0, !wr});
        rdata = db_out;
        if (!wr) begin
            if (mem_rd) exp_rd = rd_capture;
            check("read_data", {24'h0, db_out}, {24'h0, exp_rd});
        end
        EppAstb = 1'b1;
        EppDstb = 1'b1;
        n = 0;
        while (n < 12) begin
            @(negedge clk);
            n++;
            if (!EppWait) break;
        end
        check("wait_fall_latency", n, 3);
        check("db_oe_released", {31'h0, db_oe}, 32'h0);
    endtask

    logic [7:0] dummy;

    task automatic addr_wr(input logic [7:0] a);
        epp_xfer(1'b1, 1'b0, 1'b1, a, dummy);
    endtask

    task automatic reg_wr(input logic [7:0] a, input logic [7:0] d);
        addr_wr(a);
        epp_xfer(1'b0, 1'b0, 1'b1, d, dummy);
    endtask

    task automatic reg_rd(input logic [7:0] a, output logic [7:0] d);
        addr_wr(a);
        epp_xfer(1'b0, 1'b0, 1'b0, 8'h00, d);
    endtask

    task automatic set_ptr(input logic [AW-1:0] p);
        reg_wr(8'h00, p[7:0]);
        reg_wr(8'h01, {4'h0, p[11:8]});
    endtask

    task automatic fab_peek(input logic [AW-1:0] a, input logic [7:0] exp, input string name);
        @(negedge clk);
        man_we   = 1'b0;
        man_addr = a;
        repeat (3) @(negedge clk);
        check(name, {24'h0, b_dout}, {24'h0, exp});
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    logic [7:0] rd;

    initial begin
        int n;
        rst     = 1'b1;
        EppAstb = 1'b1;
        EppDstb = 1'b1;
        EppWr   = 1'b1;
        db_in   = 8'h00;
        m_ptr   = '0;
        m_auto  = 1'b1;
        m_addr  = 8'h00;
        repeat (4) @(negedge clk);
        check("reset_wait", {31'h0, EppWait}, 32'h0);
        check("reset_oe", {31'h0, db_oe}, 32'h0);
        check("reset_bdout", {24'h0, b_dout}, 32'h0);
        check("reset_dbout", {24'h0, db_out}, 32'h0);
        rst = 1'b0;
        chk_on = 1'b1;

        // Known memory image: mem[i] = i[7:0] ^ 0x3C.
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            man_we   = 1'b1;
            man_addr = AW'(i);
            man_din  = 8'(i) ^ 8'h3C;
        end
        @(negedge clk);
        man_we = 1'b0;
        repeat (3) @(negedge clk);

        // Reset-value registers and address readback.
        reg_rd(8'h03, rd);
        check("ctrl_reset", {24'h0, rd}, 32'h01);
        reg_rd(8'h04, rd);
        check("id_value", {24'h0, rd}, 32'hA5);
        epp_xfer(1'b1, 1'b0, 1'b0, 8'h00, rd);
        check("addr_readback", {24'h0, rd}, 32'h04);

        // Pointer wrap with auto-increment.
        reg_wr(8'h00, 8'hFE);
        reg_wr(8'h01, 8'h0F);
        addr_wr(8'h02);
        epp_xfer(1'b0, 1'b0, 1'b1, 8'h11, dummy);
        epp_xfer(1'b0, 1'b0, 1'b1, 8'h22, dummy);
        epp_xfer(1'b0, 1'b0, 1'b1, 8'h33, dummy);
        epp_xfer(1'b0, 1'b0, 1'b1, 8'h44, dummy);
        reg_rd(8'h00, rd);
        check("wrap_ptr_l", {24'h0, rd}, 32'h02);
        reg_rd(8'h01, rd);
        check("wrap_ptr_h", {24'h0, rd}, 32'h00);
        fab_peek(12'hFFE, 8'h11, "mem_ffe");
        fab_peek(12'hFFF, 8'h22, "mem_fff");
        fab_peek(12'h000, 8'h33, "mem_000");
        fab_peek(12'h001, 8'h44, "mem_001");

        // Auto-increment disabled: repeated reads hit one byte.
        reg_wr(8'h03, 8'h00);
        set_ptr(12'h010);
        addr_wr(8'h02);
        for (int i = 0; i < 3; i++) begin
            epp_xfer(1'b0, 1'b0, 1'b0, 8'h00, rd);
            check("noinc_read", {24'h0, rd}, 32'h2C);
        end
        reg_rd(8'h00, rd);
        check("noinc_ptr_l", {24'h0, rd}, 32'h10);

        // Fabric write seen by host, host write seen by fabric.
        @(negedge clk);
        man_we = 1'b1; man_addr = 12'h123; man_din = 8'h5A;
        @(negedge clk);
        man_we = 1'b0;
        repeat (3) @(negedge clk);
        set_ptr(12'h123);
        addr_wr(8'h02);
        epp_xfer(1'b0, 1'b0, 1'b0, 8'h00, rd);
        check("host_sees_fabric", {24'h0, rd}, 32'h5A);
        set_ptr(12'h200);
        addr_wr(8'h02);
        epp_xfer(1'b0, 1'b0, 1'b1, 8'hC3, dummy);
        fab_peek(12'h200, 8'hC3, "fabric_sees_host");

        // Same-cycle collision at 0x050: EPP write must win.
        set_ptr(12'h050);
        addr_wr(8'h02);
        coll_din = 8'h88;
        collide  = 1'b1;
        epp_xfer(1'b0, 1'b0, 1'b1, 8'h77, dummy);
        collide  = 1'b0;
        fab_peek(12'h050, 8'h77, "collision_fabric");
        epp_xfer(1'b0, 1'b0, 1'b0, 8'h00, rd);
        check("collision_host", {24'h0, rd}, 32'h77);

        // Both strobes low together is an address cycle.
        epp_xfer(1'b1, 1'b1, 1'b1, 8'h04, dummy);
        epp_xfer(1'b0, 1'b0, 1'b0, 8'h00, rd);
        check("both_strobes_addr", {24'h0, rd}, 32'hA5);

        // Randomised traffic on both ports.
        reg_wr(8'h03, 8'h01);
        fab_rand = 1'b1;
        for (int i = 0; i < 200; i++) begin
            int kind;
            int a;
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    a = $urandom_range(0, 9);
                    if (a > 6) a = 2;
                    addr_wr(8'(a));
                end
                1: epp_xfer(1'b1, 1'b0, 1'b0, 8'h00, rd);
                2: epp_xfer(1'b0, 1'b0, 1'b1, 8'($urandom), dummy);
                default: epp_xfer(1'b0, 1'b0, 1'b0, 8'h00, rd);
            endcase
        end
        fab_rand = 1'b0;
        repeat (3) @(negedge clk);

        // Reset pulsed while a transfer sits in ACK.
        reg_wr(8'h03, 8'h01);
        set_ptr(12'h123);
        m_addr = 8'h00;
        addr_wr(8'h00);
        @(negedge clk);
        EppWr   = 1'b1;
        EppDstb = 1'b0;
        n = 0;
        while (n < 12) begin
            @(negedge clk);
            n++;
            if (EppWait) break;
        end
        check("pre_reset_rise", n, 3);
        check("pre_reset_data", {24'h0, db_out}, 32'h23);
        rst = 1'b1;
        @(negedge clk);
        check("rst_drops_wait", {31'h0, EppWait}, 32'h0);
        check("rst_drops_oe", {31'h0, db_oe}, 32'h0);
        rst    = 1'b0;
        m_ptr  = '0;
        m_auto = 1'b1;
        m_addr = 8'h00;
        n = 0;
        while (n < 12) begin
            @(negedge clk);
            n++;
            if (EppWait) break;
        end
        check("held_strobe_restarts", {31'h0, EppWait}, 32'h1);
        check("post_reset_ptr_l", {24'h0, db_out}, 32'h00);
        check("post_reset_oe", {31'h0, db_oe}, 32'h1);
        EppDstb = 1'b1;
        n = 0;
        while (n < 12) begin
            @(negedge clk);
            n++;
            if (!EppWait) break;
        end
        check("post_reset_release", n, 3);
        reg_rd(8'h01, rd);
        check("post_reset_ptr_h", {24'h0, rd}, 32'h00);
        reg_rd(8'h03, rd);
        check("post_reset_ctrl", {24'h0, rd}, 32'h01);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/epp_bram_bridge.md
# epp_bram_bridge

Parametrised EPP-slave-to-dual-port-RAM bridge with an internal register file and an auto-incrementing memory pointer. The host reaches all memory through one data register, with no address cycle per byte. A second synchronous port gives on-chip logic concurrent access to the same memory. It sits between the board-level DB tristate pads and fabric consumers such as display or capture logic. Everything runs on one clock domain.

## Interface

Parameters:
- `ADDR_W`, 12: memory address width (9..16); depth = 2^ADDR_W bytes.
- `ID`, 8'hA5: value returned by the ID register.

Ports:
- `clk`, in, 1: system clock; all logic on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `EppAstb`, in, 1: EPP address strobe, active low, asynchronous to `clk`.
- `EppDstb`, in, 1: EPP data strobe, active low, asynchronous.
- `EppWr`, in, 1: 0 = host write, 1 = host read; asynchronous.
- `db_in`, in, 8: DB pad input value.
- `db_out`, out, 8: value driven on DB when `db_oe`=1.
- `db_oe`, out, 1: DB output enable; the top-level tristate uses it.
- `EppWait`, out, 1: handshake acknowledge to the host.
- `b_addr`, in, ADDR_W: fabric port address.
- `b_din`, in, 8: fabric write data.
- `b_we`, in, 1: fabric write enable.
- `b_dout`, out, 8: fabric read data, 1-cycle latency.

## Operation

- `EppAstb`, `EppDstb` and `EppWr` each pass through a 2-FF synchroniser; the FSM sees only the synchronised versions `astb_s`, `dstb_s` and `wr_s`.
- `db_in` is sampled only in IDLE, when a synchronised strobe is low, so it is stable by then.
- Register map, selected by the 8-bit `epp_addr`:
  - 0x00 PTR_L: RW, pointer[7:0].
  - 0x01 PTR_H: RW, pointer[ADDR_W-1:8]; unused bits read 0.
  - 0x02 DATA: RW, mem[pointer].
  - 0x03 CTRL: RW; bit0 = auto-increment enable (reset 1); other bits read 0.
  - 0x04 ID: RO, returns `ID`.
  - Any other address reads 0x00; writes to it are ignored.
- Auto-increment:
  - Applies after every DATA access, read or write, when CTRL[0]=1.
  - The pointer wraps from 2^ADDR_W-1 to 0.
  - Non-DATA accesses never move the pointer.
- FSM states: IDLE, RDMEM, ACK.
  - IDLE, `astb_s`=0 (has priority over `dstb_s` if both are low):
    - If `wr_s`=0: `epp_addr` <= `db_in`.
    - Otherwise: `db_out` <= `epp_addr`.
    - Go to ACK.
  - IDLE, `dstb_s`=0, write: update the selected register, or write mem[pointer] for DATA; go to ACK.
  - IDLE, `dstb_s`=0, read of DATA: issue the RAM read; go to RDMEM.
  - IDLE, `dstb_s`=0, read of any other register: `db_out` <= register value; go to ACK.
  - RDMEM: `db_out` <= RAM output; go to ACK.
  - ACK:
    - `EppWait`=1; `db_oe`=`wr_s` latched at cycle start.
    - Stay in ACK until `astb_s`=1 and `dstb_s`=1.
    - Then go to IDLE with `EppWait`=0 and `db_oe`=0.
- Port B:
  - Read-first: a same-cycle read and write at one address returns the old data.
  - EPP write and `b_we` to the same address in the same cycle: the EPP write wins and the port-B write is suppressed.
- RAM contents are not cleared by reset.

## Timing

- Reset values:
  - State IDLE.
  - `EppWait`=0, `db_oe`=0, `db_out`=0x00, `b_dout`=0x00.
  - `epp_addr`=0x00, pointer=0, CTRL=0x01.
- Strobe falling edge to `EppWait` rising:
  - 3 cycles for address cycles, register accesses and DATA writes.
  - 4 cycles for DATA reads.
- Strobe rising edge to `EppWait` falling: 3 cycles.
- `db_oe` and `EppWait` assert in the same cycle on reads; `db_out` is stable before then.
- The pointer update, when enabled, lands in the cycle `EppWait` rises, so back-to-back DATA cycles need no host delay.
- `rst` asserted mid-transaction:
  - Forces IDLE next cycle; `EppWait` and `db_oe` drop immediately.
  - A strobe still held low after reset release starts a new transaction.

## Test plan

- Reset → `EppWait`=0, `db_oe`=0, `b_dout`=0. Then read addresses 0x03 and 0x04 → 0x01 and 0xA5.
- Write PTR_L=0xFE and PTR_H=0x0F, then 4 DATA writes 0x11..0x44 → mem[0xFFE]=0x11, mem[0xFFF]=0x22, mem[0x000]=0x33, mem[0x001]=0x44; final pointer 0x002.
- Write CTRL=0x00, set pointer to 0x010, do 3 DATA reads → the same byte each time; pointer stays 0x010. Read latency is 4 cycles, register latency 3.
- Fabric port: `b_we` writes 0x5A at 0x123; the host then reads DATA at 0x123 → 0x5A. The host writes 0xC3 at 0x200 → `b_dout`=0xC3 one cycle after `b_addr`=0x200.
- Collision: EPP DATA write 0x77 and `b_we` 0x88 in the same cycle at address 0x050 → mem[0x050]=0x77.
- Astb and Dstb both low together → treated as an address cycle. Separately, `rst` pulsed in ACK → `EppWait` low the next cycle and pointer reset to 0.
